servant_ram_arbiter: RTL and testbench
======================================

Name: servant_ram_arbiter

Overview:
Shares the single-port servant RAM Wishbone slave between the SERV CPU data/instruction bus and a BLE UART receive stream. Received bytes are buffered in a small FIFO and written as single-byte Wishbone writes into a circular region of RAM [RING_LO, RING_HI]. The block sits between servant/uart_rx and servant_ram and replaces ad-hoc cyc/we/adr muxing with a proper grant state machine, so CPU transfers are never corrupted and no byte is silently lost.

Parameters:
RING_LO, 32'h00C00000, first byte address of RX ring region.
RING_HI, 32'h00C0FFFF, last byte address of RX ring region (inclusive, RING_HI >= RING_LO).
FIFO_DEPTH, 4, RX byte FIFO entries (power of two, >= 2).

Ports:
i_wb_clk  in  1  clock
i_wb_rst  in  1  synchronous active-high reset
i_cpu_adr  in  32  CPU Wishbone address
i_cpu_dat  in  32  CPU write data
i_cpu_sel  in  4  CPU byte selects
i_cpu_we  in  1  CPU write enable
i_cpu_cyc  in  1  CPU cycle request
o_cpu_rdt  out  32  read data to CPU
o_cpu_ack  out  1  ack to CPU
i_rx_valid  in  1  one-cycle strobe, new byte from uart_rx
i_rx_data  in  8  received byte
o_ram_adr  out  32  RAM address
o_ram_dat  out  32  RAM write data
o_ram_sel  out  4  RAM byte selects
o_ram_we  out  1  RAM write enable
o_ram_cyc  out  1  RAM cycle
i_ram_rdt  in  32  RAM read data
i_ram_ack  in  1  RAM ack
o_wr_ptr  out  32  next ring byte address to be written
o_fifo_cnt  out  $clog2(FIFO_DEPTH)+1  FIFO occupancy
o_ovf  out  1  sticky overflow flag

Behaviour:
- Reset: state IDLE, all o_ram_* = 0, o_cpu_ack = 0, o_wr_ptr = RING_LO, FIFO empty, o_fifo_cnt = 0, o_ovf = 0, last_grant = RX, holdoff = 0. o_cpu_rdt is don't-care when o_cpu_ack = 0.
- FIFO: push on i_rx_valid when not full; visible in o_fifo_cnt next cycle. Push while full: byte dropped, o_ovf <= 1 (sticky until reset). Push and pop in the same cycle with FIFO full: pop frees the slot, so push is accepted; no overflow.
- States: IDLE, CPU, RX.
- IDLE: cpu_req = i_cpu_cyc & !holdoff; rx_req = FIFO non-empty.
  - Only one request -> grant it.
  - Both requests -> round-robin: grant whichever was NOT last_grant.
  - Grant registers the o_ram_* outputs on the same edge the state changes; o_ram_cyc is high the cycle after the grant decision.
- CPU: o_ram_adr/dat/sel/we = registered copy of the CPU request; o_ram_cyc = 1.
  - On i_ram_ack: o_cpu_ack = 1 and o_cpu_rdt = i_ram_rdt, both combinational in that cycle only.
  - Next edge: state IDLE, o_ram_cyc = 0, last_grant = CPU, holdoff = 1 for exactly one cycle, so the CPU's still-high cyc is not re-granted.
- RX: o_ram_adr = o_wr_ptr; o_ram_dat = {4{fifo_head}}; o_ram_sel = 4'b0001 << o_wr_ptr[1:0]; o_ram_we = 1; o_ram_cyc = 1.
  - On i_ram_ack: pop FIFO, o_wr_ptr <= (o_wr_ptr == RING_HI) ? RING_LO : o_wr_ptr + 1, last_grant = RX.
  - Next edge: state IDLE, o_ram_cyc = 0.
- o_cpu_ack is never asserted outside the CPU state. RAM acks in IDLE are ignored.
- No preemption: a grant is held until i_ram_ack. Worst-case CPU wait is one RX transfer.
- Minimum turnaround: grant cycle + RAM cycle(s) + 1 IDLE cycle. With servant_ram's 1-cycle ack this is 3 cycles per transfer.
- A CPU access to the ring region is not blocked (the CPU reads the ring). Arbiter ordering guarantees no torn accesses.
- Reset mid-transfer: outputs return to their reset values on the next edge, the FIFO is flushed, and any in-flight RAM ack is ignored.

Test Plan:
- CPU only: read of 0x100 with RAM acking 1 cycle after cyc -> o_ram_cyc high 1 cycle after i_cpu_cyc; o_cpu_ack pulses for exactly 1 cycle with o_cpu_rdt = i_ram_rdt; cyc held by the CPU for 1 extra cycle is not re-granted (holdoff).
- RX only: bytes 0x41, 0x42, 0x43, 0x44, 0x45 -> writes to 0xC00000..0xC00004 with sel 0001, 0010, 0100, 1000, 0001 and dat 0x41414141, ...; o_wr_ptr ends at 0xC00005.
- Contention: CPU cyc and 1 FIFO byte pending in the same IDLE cycle with last_grant = RX -> CPU granted first, RX next; repeat with last_grant = CPU -> RX first.
- Wrap: RING_LO = 0x10, RING_HI = 0x13, 5 bytes -> addresses 0x10, 0x11, 0x12, 0x13, 0x10; o_wr_ptr = 0x11.
- Overflow: stall i_ram_ack with the CPU granted, strobe 5 bytes with FIFO_DEPTH = 4 -> o_fifo_cnt = 4, o_ovf = 1, 5th byte never written; first 4 bytes drain in order once acks resume.
- Reset mid-RX-write: assert i_wb_rst while o_ram_cyc = 1 -> next cycle o_ram_cyc = 0, o_fifo_cnt = 0, o_wr_ptr = RING_LO, o_ovf = 0.

Source files
------------

// File: rtl/servant_ram_arbiter_if.sv
// Wishbone bus bundle shared by the CPU side and the RAM side of the
// servant RAM arbiter.
interface servant_ram_arbiter_if;
  logic [31:0] adr;
  logic [31:0] dat;
  logic [3:0]  sel;
  logic        we;
  logic        cyc;
  logic [31:0] rdt;
  logic        ack;

  modport master (
    output adr,
    output dat,
    output sel,
    output we,
    output cyc,
    input  rdt,
    input  ack
  );

  modport slave (
    input  adr,
    input  dat,
    input  sel,
    input  we,
    input  cyc,
    output rdt,
    output ack
  );
endinterface

// File: rtl/servant_ram_arbiter.sv
// Grants the single-port servant RAM to either the SERV CPU bus or a
// buffered UART RX byte stream written into a circular RAM ring.
module servant_ram_arbiter #(
  parameter logic [31:0] RING_LO    = 32'h00C0_0000,
  parameter logic [31:0] RING_HI    = 32'h00C0_FFFF,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic                          i_wb_clk,
  input  logic                          i_wb_rst,
  servant_ram_arbiter_if.slave          cpu,
  servant_ram_arbiter_if.master         ram,
  input  logic                          i_rx_valid,
  input  logic [7:0]                    i_rx_data,
  output logic [31:0]                   o_wr_ptr,
  output logic [$clog2(FIFO_DEPTH):0]   o_fifo_cnt,
  output logic                          o_ovf
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CPU,
    S_RX
  } state_e;

  typedef enum logic {
    G_CPU,
    G_RX
  } grant_e;

  state_e      state_q, state_d;
  grant_e      last_q, last_d;
  logic        holdoff_q, holdoff_d;

  logic [31:0] ram_adr_q, ram_adr_d;
  logic [31:0] ram_dat_q, ram_dat_d;
  logic [3:0]  ram_sel_q, ram_sel_d;
  logic        ram_we_q, ram_we_d;
  logic        ram_cyc_q, ram_cyc_d;

  logic [31:0] wr_ptr_q, wr_ptr_d;
  logic        ovf_q, ovf_d;

  logic [7:0]  mem_q [FIFO_DEPTH];
  logic [7:0]  mem_d [FIFO_DEPTH];
  logic [AW-1:0] fwp_q, fwp_d;
  logic [AW-1:0] frp_q, frp_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic        full;
  logic        push;
  logic        pop;
  logic        cpu_req;
  logic        rx_req;
  logic        grant_cpu;
  logic        grant_rx;
  logic [7:0]  head;
  logic [31:0] wr_ptr_nxt;

  assign full   = (cnt_q == CW'(FIFO_DEPTH));
  assign head   = mem_q[frp_q];
  assign rx_req = (cnt_q != '0);

  // holdoff masks the CPU cyc that is still high right after its ack
  assign cpu_req = cpu.cyc & ~holdoff_q;

  assign grant_cpu = cpu_req & (~rx_req | (last_q == G_RX));
  assign grant_rx  = rx_req & ~grant_cpu;

  assign wr_ptr_nxt = (wr_ptr_q == RING_HI) ? RING_LO
                                            : wr_ptr_q + 32'd1;

  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    holdoff_d = 1'b0;
    ram_adr_d = ram_adr_q;
    ram_dat_d = ram_dat_q;
    ram_sel_d = ram_sel_q;
    ram_we_d  = ram_we_q;
    ram_cyc_d = ram_cyc_q;
    wr_ptr_d  = wr_ptr_q;
    pop       = 1'b0;
    cpu.ack   = 1'b0;
    cpu.rdt   = ram.rdt;

    unique case (state_q)
      S_IDLE: begin
        if (grant_cpu) begin
          state_d   = S_CPU;
          ram_adr_d = cpu.adr;
          ram_dat_d = cpu.dat;
          ram_sel_d = cpu.sel;
          ram_we_d  = cpu.we;
          ram_cyc_d = 1'b1;
        end else if (grant_rx) begin
          state_d   = S_RX;
          ram_adr_d = wr_ptr_q;
          ram_dat_d = {4{head}};
          ram_sel_d = 4'b0001 << wr_ptr_q[1:0];
          ram_we_d  = 1'b1;
          ram_cyc_d = 1'b1;
        end
      end
      S_CPU: begin
        if (ram.ack) begin
          cpu.ack   = 1'b1;
          state_d   = S_IDLE;
          last_d    = G_CPU;
          holdoff_d = 1'b1;
          ram_adr_d = '0;
          ram_dat_d = '0;
          ram_sel_d = '0;
          ram_we_d  = 1'b0;
          ram_cyc_d = 1'b0;
        end
      end
      S_RX: begin
        if (ram.ack) begin
          pop       = 1'b1;
          wr_ptr_d  = wr_ptr_nxt;
          state_d   = S_IDLE;
          last_d    = G_RX;
          ram_adr_d = '0;
          ram_dat_d = '0;
          ram_sel_d = '0;
          ram_we_d  = 1'b0;
          ram_cyc_d = 1'b0;
        end
      end
      default: begin
        state_d   = S_IDLE;
        ram_cyc_d = 1'b0;
      end
    endcase
  end

  // a pop in the same cycle frees the slot for a push into a full FIFO
  always_comb begin
    push  = i_rx_valid & (~full | pop);
    ovf_d = ovf_q | (i_rx_valid & full & ~pop);
    fwp_d = push ? fwp_q + AW'(1) : fwp_q;
    frp_d = pop ? frp_q + AW'(1) : frp_q;
    cnt_d = cnt_q + CW'(push) - CW'(pop);
    mem_d = mem_q;
    if (push) begin
      mem_d[fwp_q] = i_rx_data;
    end
  end

  always_ff @(posedge i_wb_clk) begin
    if (i_wb_rst) begin
      state_q   <= S_IDLE;
      last_q    <= G_RX;
      holdoff_q <= 1'b0;
      ram_adr_q <= '0;
      ram_dat_q <= '0;
      ram_sel_q <= '0;
      ram_we_q  <= 1'b0;
      ram_cyc_q <= 1'b0;
      wr_ptr_q  <= RING_LO;
      ovf_q     <= 1'b0;
      fwp_q     <= '0;
      frp_q     <= '0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      last_q    <= last_d;
      holdoff_q <= holdoff_d;
      ram_adr_q <= ram_adr_d;
      ram_dat_q <= ram_dat_d;
      ram_sel_q <= ram_sel_d;
      ram_we_q  <= ram_we_d;
      ram_cyc_q <= ram_cyc_d;
      wr_ptr_q  <= wr_ptr_d;
      ovf_q     <= ovf_d;
      fwp_q     <= fwp_d;
      frp_q     <= frp_d;
      cnt_q     <= cnt_d;
    end
  end

  always_ff @(posedge i_wb_clk) begin
    mem_q <= mem_d;
  end

  assign ram.adr    = ram_adr_q;
  assign ram.dat    = ram_dat_q;
  assign ram.sel    = ram_sel_q;
  assign ram.we     = ram_we_q;
  assign ram.cyc    = ram_cyc_q;
  assign o_wr_ptr   = wr_ptr_q;
  assign o_fifo_cnt = cnt_q;
  assign o_ovf      = ovf_q;

endmodule

// File: tb/tb_servant_ram_arbiter.sv
// Directed bench for servant_ram_arbiter: CPU path, RX ring writes,
// contention, wrap, overflow and reset, with a write scoreboard.
module tb_servant_ram_arbiter;

  localparam logic [31:0] LO  = 32'h00C0_0000;
  localparam logic [31:0] HI  = 32'h00C0_FFFF;
  localparam logic [31:0] WLO = 32'h0000_0010;
  localparam logic [31:0] WHI = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] adr;
    logic [3:0]  sel;
    logic [31:0] dat;
  } wr_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall_a = 1'b0;
  logic        rxv_a, rxv_b;
  logic [7:0]  rxd_a, rxd_b;
  logic [31:0] wp_a, wp_b;
  logic [2:0]  cnt_a, cnt_b;
  logic        ovf_a, ovf_b;
  logic [31:0] ep_a, ep_b;

  int n_vec = 0;
  int n_err = 0;

  wr_t sb_a[$];
  wr_t sb_b[$];

  always #5 clk = ~clk;

  servant_ram_arbiter_if cpu_a ();
  servant_ram_arbiter_if ram_a ();
  servant_ram_arbiter_if cpu_b ();
  servant_ram_arbiter_if ram_b ();

  servant_ram_arbiter u_a (
    .i_wb_clk   (clk),
    .i_wb_rst   (rst),
    .cpu        (cpu_a),
    .ram        (ram_a),
    .i_rx_valid (rxv_a),
    .i_rx_data  (rxd_a),
    .o_wr_ptr   (wp_a),
    .o_fifo_cnt (cnt_a),
    .o_ovf      (ovf_a)
  );

  servant_ram_arbiter #(
    .RING_LO (WLO),
    .RING_HI (WHI)
  ) u_b (
    .i_wb_clk   (clk),
    .i_wb_rst   (rst),
    .cpu        (cpu_b),
    .ram        (ram_b),
    .i_rx_valid (rxv_b),
    .i_rx_data  (rxd_b),
    .o_wr_ptr   (wp_b),
    .o_fifo_cnt (cnt_b),
    .o_ovf      (ovf_b)
  );

  // servant_ram-like slaves: ack one cycle after cyc, unless stalled
  always @(posedge clk) begin
    ram_a.ack <= ram_a.cyc & ~ram_a.ack & ~stall_a;
    ram_b.ack <= ram_b.cyc & ~ram_b.ack;
  end
  assign ram_a.rdt = {16'hA5A5, ram_a.adr[15:0]};
  assign ram_b.rdt = 32'h0;

  task automatic chk(input string tag, input logic [71:0] obs,
                     input logic [71:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    wr_t got;
    wr_t exp;
    if (ram_a.cyc === 1'b1 && ram_a.ack === 1'b1 && ram_a.we === 1'b1) begin
      got = '{adr: ram_a.adr, sel: ram_a.sel, dat: ram_a.dat};
      chk("a_cpu_ack_in_rx", 72'(cpu_a.ack), 72'(0));
      chk("a_write_expected", 72'(sb_a.size() != 0), 72'(1));
      if (sb_a.size() != 0) begin
        exp = sb_a.pop_front();
        chk("a_write", 72'(got), 72'(exp));
      end
    end
    if (ram_b.cyc === 1'b1 && ram_b.ack === 1'b1 && ram_b.we === 1'b1) begin
      got = '{adr: ram_b.adr, sel: ram_b.sel, dat: ram_b.dat};
      chk("b_write_expected", 72'(sb_b.size() != 0), 72'(1));
      if (sb_b.size() != 0) begin
        exp = sb_b.pop_front();
        chk("b_write", 72'(got), 72'(exp));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_a(input logic [7:0] b, input bit kept);
    wr_t e;
    rxv_a = 1'b1;
    rxd_a = b;
    if (kept) begin
      e.adr = ep_a;
      e.sel = 4'b0001 << ep_a[1:0];
      e.dat = {4{b}};
      sb_a.push_back(e);
      ep_a = (ep_a == HI) ? LO : ep_a + 32'd1;
    end
    step();
    rxv_a = 1'b0;
  endtask

  task automatic send_b(input logic [7:0] b);
    wr_t e;
    rxv_b = 1'b1;
    rxd_b = b;
    e.adr = ep_b;
    e.sel = 4'b0001 << ep_b[1:0];
    e.dat = {4{b}};
    sb_b.push_back(e);
    ep_b = (ep_b == WHI) ? WLO : ep_b + 32'd1;
    step();
    rxv_b = 1'b0;
  endtask

  task automatic drain_a(input string tag);
    for (int i = 0; i < 100 && sb_a.size() != 0; i++) step();
    chk(tag, 72'(sb_a.size()), 72'(0));
    step();
    step();
  endtask

  task automatic cpu_done_a(input string tag, input logic [31:0] adr);
    for (int i = 0; i < 40 && cpu_a.ack !== 1'b1; i++) step();
    chk({tag, "_ack"}, 72'(cpu_a.ack), 72'(1));
    chk({tag, "_rdt"}, 72'(cpu_a.rdt), 72'({16'hA5A5, adr[15:0]}));
    cpu_a.cyc = 1'b0;
    step();
  endtask

  initial begin
    cpu_a.adr = '0; cpu_a.dat = '0; cpu_a.sel = '0;
    cpu_a.we  = 1'b0; cpu_a.cyc = 1'b0;
    cpu_b.adr = '0; cpu_b.dat = '0; cpu_b.sel = '0;
    cpu_b.we  = 1'b0; cpu_b.cyc = 1'b0;
    rxv_a = 1'b0; rxd_a = '0;
    rxv_b = 1'b0; rxd_b = '0;
    ep_a = LO;
    ep_b = WLO;

    repeat (3) step();
    chk("rst_cyc", 72'(ram_a.cyc), 72'(0));
    chk("rst_bus", 72'({ram_a.adr, ram_a.dat, ram_a.sel, ram_a.we}), 72'(0));
    chk("rst_cpu_ack", 72'(cpu_a.ack), 72'(0));
    chk("rst_wr_ptr", 72'(wp_a), 72'(LO));
    chk("rst_cnt", 72'(cnt_a), 72'(0));
    chk("rst_ovf", 72'(ovf_a), 72'(0));
    chk("rst_wr_ptr_b", 72'(wp_b), 72'(WLO));
    rst = 1'b0;
    step();

    // CPU-only read of 0x100, cyc held one extra cycle
    cpu_a.adr = 32'h100; cpu_a.sel = 4'hF; cpu_a.we = 1'b0;
    cpu_a.cyc = 1'b1;
    step();
    chk("cpu_cyc", 72'(ram_a.cyc), 72'(1));
    chk("cpu_adr", 72'(ram_a.adr), 72'(32'h100));
    chk("cpu_we", 72'(ram_a.we), 72'(0));
    chk("cpu_no_early_ack", 72'(cpu_a.ack), 72'(0));
    step();
    chk("cpu_ack", 72'(cpu_a.ack), 72'(1));
    chk("cpu_rdt", 72'(cpu_a.rdt), 72'(32'hA5A5_0100));
    step();
    chk("cpu_ack_pulse", 72'(cpu_a.ack), 72'(0));
    chk("cpu_release", 72'(ram_a.cyc), 72'(0));
    step();
    chk("cpu_holdoff", 72'(ram_a.cyc), 72'(0));
    cpu_a.cyc = 1'b0;
    step();

    // RX-only stream
    for (int i = 0; i < 5; i++) begin
      send_a(8'h41 + 8'(i), 1'b1);
      step();
      step();
    end
    drain_a("rx_drain");
    chk("rx_wr_ptr", 72'(wp_a), 72'(LO + 32'd5));
    chk("rx_cnt", 72'(cnt_a), 72'(0));

    // contention, last grant RX -> CPU first
    send_a(8'h51, 1'b1);
    cpu_a.adr = 32'h204; cpu_a.cyc = 1'b1;
    step();
    chk("c1_cpu_first", 72'({ram_a.cyc, ram_a.we}), 72'(2'b10));
    chk("c1_cpu_adr", 72'(ram_a.adr), 72'(32'h204));
    cpu_done_a("c1_cpu", 32'h204);
    for (int i = 0; i < 10 && ram_a.cyc !== 1'b1; i++) step();
    chk("c1_rx_second", 72'({ram_a.cyc, ram_a.we}), 72'(2'b11));
    drain_a("c1_drain");

    // contention, last grant CPU -> RX first
    cpu_a.adr = 32'h300; cpu_a.cyc = 1'b1;
    cpu_done_a("c2_pre", 32'h300);
    step();
    step();
    send_a(8'h52, 1'b1);
    cpu_a.adr = 32'h304; cpu_a.cyc = 1'b1;
    step();
    chk("c2_rx_first", 72'({ram_a.cyc, ram_a.we}), 72'(2'b11));
    cpu_done_a("c2_cpu", 32'h304);
    drain_a("c2_drain");

    // overflow while the CPU holds a stalled grant
    stall_a = 1'b1;
    cpu_a.adr = 32'h400; cpu_a.cyc = 1'b1;
    step();
    chk("ovf_cpu_held", 72'({ram_a.cyc, ram_a.we}), 72'(2'b10));
    for (int i = 0; i < 4; i++) send_a(8'h61 + 8'(i), 1'b1);
    chk("ovf_full_cnt", 72'(cnt_a), 72'(4));
    chk("ovf_full_no_ovf", 72'(ovf_a), 72'(0));
    send_a(8'h65, 1'b0);
    chk("ovf_cnt", 72'(cnt_a), 72'(4));
    chk("ovf_flag", 72'(ovf_a), 72'(1));
    stall_a = 1'b0;
    cpu_done_a("ovf_cpu", 32'h400);
    drain_a("ovf_drain");
    chk("ovf_sticky", 72'(ovf_a), 72'(1));
    chk("ovf_wr_ptr", 72'(wp_a), 72'(ep_a));

    // reset in the middle of an RX write
    send_a(8'h71, 1'b0);
    step();
    chk("mr_rx_active", 72'({ram_a.cyc, ram_a.we}), 72'(2'b11));
    rst = 1'b1;
    step();
    chk("mr_cyc", 72'(ram_a.cyc), 72'(0));
    chk("mr_cnt", 72'(cnt_a), 72'(0));
    chk("mr_wr_ptr", 72'(wp_a), 72'(LO));
    chk("mr_ovf", 72'(ovf_a), 72'(0));
    rst = 1'b0;
    ep_a = LO;
    step();
    chk("mr_ack_ignored", 72'(cpu_a.ack), 72'(0));
    step();
    chk("mr_no_regrant", 72'(ram_a.cyc), 72'(0));
    chk("mr_wr_ptr_hold", 72'(wp_a), 72'(LO));

    // ring wrap on the small-ring instance
    for (int i = 0; i < 5; i++) begin
      send_b(8'h81 + 8'(i));
      step();
      step();
    end
    for (int i = 0; i < 100 && sb_b.size() != 0; i++) step();
    step();
    chk("wrap_drain", 72'(sb_b.size()), 72'(0));
    chk("wrap_wr_ptr", 72'(wp_b), 72'(32'h11));
    chk("wrap_cnt", 72'(cnt_b), 72'(0));
    chk("end_sb_a", 72'(sb_a.size()), 72'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
